mc8051_xbus_bridge: RTL and testbench

Downstream of the core's bus interface unit; consumes its naive-memory interface (level strobes `mem_we_n`/`mem_rd_n`/`mem_psen_n`, `mem_addr`, `mem_wdata`). Converts each request into a classic 8051 multiplexed external-bus cycle on P0/P2, with ALE, PSEN_n, RD_n and WR_n. Returns read data and a one-cycle `mem_data_rdy` pulse to the bus interface unit. Wait-state counts are parameterised so that slow external ROM/RAM can be attached.

---
 rtl/mc8051_xbus_bridge_pkg.sv | 31 +++
 rtl/mc8051_xbus_bridge.sv | 160 ++++++++++++++++
 tb/tb_mc8051_xbus_bridge.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mc8051_xbus_bridge_pkg.sv
// Shared encodings for the 8051 external-bus bridge: FSM states, op codes and the latched request.
package mc8051_xbus_bridge_pkg;

    localparam int unsigned XB_ST_W  = 3;
    localparam int unsigned XB_OP_W  = 2;
    localparam int unsigned XB_CNT_W = 4;

    localparam logic [2:0] XB_IDLE   = 3'd0;
    localparam logic [2:0] XB_ADDR   = 3'd1;
    localparam logic [2:0] XB_SETUP  = 3'd2;
    localparam logic [2:0] XB_STROBE = 3'd3;
    localparam logic [2:0] XB_HOLD   = 3'd4;

    localparam logic [1:0] XB_OP_FETCH = 2'd0;
    localparam logic [1:0] XB_OP_READ  = 2'd1;
    localparam logic [1:0] XB_OP_WRITE = 2'd2;

    typedef struct packed {
        logic [XB_OP_W-1:0] op;
        logic [15:0]        addr;
        logic [7:0]         wdata;
    } xb_req_t;

    // Write wins over read, read over fetch.
    function automatic logic [XB_OP_W-1:0] xb_pick_op(input logic we_n, input logic rd_n);
        if (!we_n)      return XB_OP_WRITE;
        else if (!rd_n) return XB_OP_READ;
        else            return XB_OP_FETCH;
    endfunction

endpackage

// File: rtl/mc8051_xbus_bridge.sv
// Turns naive-memory requests from the bus interface unit into multiplexed 8051 P0/P2 bus cycles
// with ALE/PSEN_n/RD_n/WR_n and parameterised wait states.
module mc8051_xbus_bridge
    import mc8051_xbus_bridge_pkg::*;
#(
    parameter int unsigned ALE_CYC  = 1,
    parameter int unsigned STB_CYC  = 2,
    parameter int unsigned HOLD_CYC = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_we_n,
    input  logic        mem_rd_n,
    input  logic        mem_psen_n,
    input  logic [15:0] mem_addr,
    input  logic [7:0]  mem_wdata,
    output logic        mem_data_rdy,
    output logic [7:0]  mem_rdata,
    output logic        xb_ale,
    output logic        xb_psen_n,
    output logic        xb_rd_n,
    output logic        xb_wr_n,
    output logic [7:0]  xb_p0_out,
    output logic        xb_p0_oe,
    input  logic [7:0]  xb_p0_in,
    output logic [7:0]  xb_p2_out
);

    logic [XB_ST_W-1:0]  state_q, state_d;
    logic [XB_CNT_W-1:0] wcnt_q, wcnt_d;
    xb_req_t             req_q, req_d;
    logic                ale_q, ale_d;
    logic                psen_n_q, psen_n_d;
    logic                rd_n_q, rd_n_d;
    logic                wr_n_q, wr_n_d;
    logic [7:0]          p0_out_q, p0_out_d;
    logic                p0_oe_q, p0_oe_d;
    logic [7:0]          p2_out_q, p2_out_d;
    logic                rdy_q, rdy_d;
    logic [7:0]          rdata_q, rdata_d;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= XB_IDLE;
            wcnt_q   <= '0;
            req_q    <= '0;
            ale_q    <= 1'b0;
            psen_n_q <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            p0_out_q <= 8'hFF;
            p0_oe_q  <= 1'b0;
            p2_out_q <= 8'hFF;
            rdy_q    <= 1'b0;
            rdata_q  <= 8'hFF;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            req_q    <= req_d;
            ale_q    <= ale_d;
            psen_n_q <= psen_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            p0_out_q <= p0_out_d;
            p0_oe_q  <= p0_oe_d;
            p2_out_q <= p2_out_d;
            rdy_q    <= rdy_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next state, then the output values of the state being entered so every pin is a flop.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        req_d    = req_q;
        ale_d    = 1'b0;
        psen_n_d = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        p0_out_d = p0_out_q;
        p0_oe_d  = 1'b0;
        p2_out_d = p2_out_q;
        rdy_d    = 1'b0;
        rdata_d  = rdata_q;

        case (state_q)
            XB_IDLE: begin
                if (!mem_we_n || !mem_rd_n || !mem_psen_n) begin
                    req_d.op    = xb_pick_op(mem_we_n, mem_rd_n);
                    req_d.addr  = mem_addr;
                    req_d.wdata = mem_wdata;
                    state_d     = XB_ADDR;
                    wcnt_d      = XB_CNT_W'(ALE_CYC - 1);
                end
            end
            XB_ADDR: begin
                if (wcnt_q == '0) state_d = XB_SETUP;
                else              wcnt_d  = wcnt_q - XB_CNT_W'(1);
            end
            XB_SETUP: begin
                state_d = XB_STROBE;
                wcnt_d  = XB_CNT_W'(STB_CYC - 1);
            end
            XB_STROBE: begin
                if (wcnt_q == '0) begin
                    state_d = XB_HOLD;
                    wcnt_d  = XB_CNT_W'(HOLD_CYC - 1);
                    rdy_d   = 1'b1;
                    if (req_q.op != XB_OP_WRITE) rdata_d = xb_p0_in;
                end else begin
                    wcnt_d = wcnt_q - XB_CNT_W'(1);
                end
            end
            XB_HOLD: begin
                if (wcnt_q == '0) state_d = XB_IDLE;
                else              wcnt_d  = wcnt_q - XB_CNT_W'(1);
            end
            default: state_d = XB_IDLE;
        endcase

        case (state_d)
            XB_ADDR: begin
                ale_d    = 1'b1;
                p0_out_d = req_d.addr[7:0];
                p0_oe_d  = 1'b1;
                p2_out_d = req_d.addr[15:8];
            end
            XB_SETUP: begin
                p0_out_d = req_d.addr[7:0];
                p0_oe_d  = 1'b1;
            end
            XB_STROBE: begin
                psen_n_d = (req_d.op != XB_OP_FETCH);
                rd_n_d   = (req_d.op != XB_OP_READ);
                wr_n_d   = (req_d.op != XB_OP_WRITE);
                if (req_d.op == XB_OP_WRITE) begin
                    p0_out_d = req_d.wdata;
                    p0_oe_d  = 1'b1;
                end
            end
            XB_HOLD: begin
                p0_oe_d = (req_d.op == XB_OP_WRITE);
            end
            default: ;
        endcase
    end

    assign mem_data_rdy = rdy_q;
    assign mem_rdata    = rdata_q;
    assign xb_ale       = ale_q;
    assign xb_psen_n    = psen_n_q;
    assign xb_rd_n      = rd_n_q;
    assign xb_wr_n      = wr_n_q;
    assign xb_p0_out    = p0_out_q;
    assign xb_p0_oe     = p0_oe_q;
    assign xb_p2_out    = p2_out_q;

endmodule

// File: tb/tb_mc8051_xbus_bridge.sv
// Bench for mc8051_xbus_bridge: a default instance and a slow (2/5/3) instance run the same
// requests; a cycle-level monitor is compared against timing and data expectations.
module tb_mc8051_xbus_bridge;

    localparam int unsigned B_ALE  = 2;
    localparam int unsigned B_STB  = 5;
    localparam int unsigned B_HOLD = 3;
    localparam int OP_F = 0;
    localparam int OP_R = 1;
    localparam int OP_W = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we_n, rd_n, psen_n;
    logic [15:0] addr;
    logic [7:0]  wdata, pad;

    logic [1:0]  rdy, ale, psn, rdn, wrn, oe;
    logic [7:0]  rdata [2];
    logic [7:0]  p0o   [2];
    logic [7:0]  p2o   [2];

    mc8051_xbus_bridge u_a (
        .clk(clk), .reset_n(reset_n),
        .mem_we_n(we_n), .mem_rd_n(rd_n), .mem_psen_n(psen_n),
        .mem_addr(addr), .mem_wdata(wdata),
        .mem_data_rdy(rdy[0]), .mem_rdata(rdata[0]),
        .xb_ale(ale[0]), .xb_psen_n(psn[0]), .xb_rd_n(rdn[0]), .xb_wr_n(wrn[0]),
        .xb_p0_out(p0o[0]), .xb_p0_oe(oe[0]), .xb_p0_in(pad), .xb_p2_out(p2o[0])
    );

    mc8051_xbus_bridge #(.ALE_CYC(B_ALE), .STB_CYC(B_STB), .HOLD_CYC(B_HOLD)) u_b (
        .clk(clk), .reset_n(reset_n),
        .mem_we_n(we_n), .mem_rd_n(rd_n), .mem_psen_n(psen_n),
        .mem_addr(addr), .mem_wdata(wdata),
        .mem_data_rdy(rdy[1]), .mem_rdata(rdata[1]),
        .xb_ale(ale[1]), .xb_psen_n(psn[1]), .xb_rd_n(rdn[1]), .xb_wr_n(wrn[1]),
        .xb_p0_out(p0o[1]), .xb_p0_oe(oe[1]), .xb_p0_in(pad), .xb_p2_out(p2o[1])
    );

    always #5 clk = ~clk;

    function automatic int ale_of(input int d);  return (d == 0) ? 1 : int'(B_ALE);  endfunction
    function automatic int stb_of(input int d);  return (d == 0) ? 2 : int'(B_STB);  endfunction
    function automatic int hold_of(input int d); return (d == 0) ? 1 : int'(B_HOLD); endfunction
    function automatic int busy_of(input int d); return ale_of(d) + 1 + stb_of(d) + hold_of(d); endfunction

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor state, cleared per transaction.
    bit          started = 1'b0;
    bit          active  = 1'b0;
    int          cyc;
    int          rdy_cnt[2], rdy_cyc[2], rdy2_cyc[2], ale_cnt[2], stb_cnt[2];
    int          ale_bad[2], data_bad[2], wrong_stb[2];
    int          excl_bad = 0;
    int          exp_op;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic [7:0]  exp_rd[2];

    task automatic clear_stats();
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            rdy_cnt[d] = 0; rdy_cyc[d] = -1; rdy2_cyc[d] = -1; ale_cnt[d] = 0; stb_cnt[d] = 0;
            ale_bad[d] = 0; data_bad[d] = 0; wrong_stb[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                int nl;
                nl = int'(!psn[d]) + int'(!rdn[d]) + int'(!wrn[d]);
                if (nl > 1 || (nl > 0 && ale[d]) || (oe[d] && (!rdn[d] || !psn[d]))) excl_bad++;
                if (active) begin
                    if (ale[d]) begin
                        ale_cnt[d]++;
                        if (p0o[d] != exp_addr[7:0] || p2o[d] != exp_addr[15:8] || !oe[d]) ale_bad[d]++;
                    end
                    if (nl == 1) begin
                        stb_cnt[d]++;
                        if ((exp_op == OP_W && wrn[d]) || (exp_op == OP_R && rdn[d]) ||
                            (exp_op == OP_F && psn[d])) wrong_stb[d]++;
                        if (exp_op == OP_W && (p0o[d] != exp_wdata || !oe[d])) data_bad[d]++;
                        if (p2o[d] != exp_addr[15:8]) data_bad[d]++;
                    end
                    if (rdy[d]) begin
                        if (rdy_cnt[d] == 0)      rdy_cyc[d]  = cyc;
                        else if (rdy_cnt[d] == 1) rdy2_cyc[d] = cyc;
                        rdy_cnt[d]++;
                        if (exp_op == OP_W && (p0o[d] != exp_wdata || !oe[d])) data_bad[d]++;
                        if (exp_op != OP_W && oe[d]) data_bad[d]++;
                        if (p2o[d] != exp_addr[15:8]) data_bad[d]++;
                    end
                end
            end
            if (active) cyc++;
        end
    end

    task automatic start_req(input logic we, input logic rd, input logic ps,
                             input logic [15:0] a, input logic [7:0] wd, input logic [7:0] pd);
        @(negedge clk);
        we_n = we; rd_n = rd; psen_n = ps; addr = a; wdata = wd; pad = pd;
        exp_op    = !we ? OP_W : (!rd ? OP_R : OP_F);
        exp_addr  = a;
        exp_wdata = wd;
        clear_stats();
        @(posedge clk);
        #1 active = 1'b1;
    endtask

    task automatic txn(input logic we, input logic rd, input logic ps,
                       input logic [15:0] a, input logic [7:0] wd, input logic [7:0] pd);
        start_req(we, rd, ps, a, wd, pd);
        @(negedge clk);
        we_n = 1'b1; rd_n = 1'b1; psen_n = 1'b1;
        addr = 16'($urandom); wdata = 8'($urandom);
        repeat (14) @(negedge clk);
        #1 active = 1'b0;
        for (int d = 0; d < 2; d++) begin
            if (exp_op != OP_W) exp_rd[d] = pd;
            chk($sformatf("rdy_cnt%0d", d),   rdy_cnt[d],   1);
            chk($sformatf("rdy_cyc%0d", d),   rdy_cyc[d],   ale_of(d) + 1 + stb_of(d));
            chk($sformatf("ale_cyc%0d", d),   ale_cnt[d],   ale_of(d));
            chk($sformatf("stb_cyc%0d", d),   stb_cnt[d],   stb_of(d));
            chk($sformatf("ale_addr%0d", d),  ale_bad[d],   0);
            chk($sformatf("bus_data%0d", d),  data_bad[d],  0);
            chk($sformatf("which_stb%0d", d), wrong_stb[d], 0);
            chk($sformatf("rdata%0d", d),     rdata[d],     exp_rd[d]);
        end
    endtask

    initial begin
        logic [2:0] r;
        reset_n = 1'b0; we_n = 1'b1; rd_n = 1'b1; psen_n = 1'b1;
        addr = '0; wdata = '0; pad = '0;
        exp_rd[0] = 8'hFF; exp_rd[1] = 8'hFF;
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("reset%0d", d),
                {ale[d], psn[d], rdn[d], wrn[d], oe[d], rdy[d], p0o[d], p2o[d], rdata[d]},
                {6'b011100, 8'hFF, 8'hFF, 8'hFF});
        @(negedge clk);
        reset_n = 1'b1;
        started = 1'b1;

        txn(1'b1, 1'b1, 1'b0, 16'h1234, 8'h00, 8'hA5);   // fetch
        txn(1'b0, 1'b1, 1'b1, 16'h80F0, 8'h5A, 8'h00);   // write
        txn(1'b0, 1'b0, 1'b1, 16'h0F0F, 8'hC3, 8'h77);   // read+write together
        txn(1'b1, 1'b0, 1'b1, 16'hBEEF, 8'h00, 8'h3C);   // read
        for (int i = 0; i < 16; i++) begin
            r = 3'($urandom_range(1, 7));
            txn(!r[2], !r[1], !r[0], 16'($urandom), 8'($urandom), 8'($urandom));
        end

        // Fetch strobe held past rdy on the default instance only.
        start_req(1'b1, 1'b1, 1'b0, 16'h4321, 8'h00, 8'h96);
        repeat (8) @(negedge clk);
        psen_n = 1'b1;
        repeat (16) @(negedge clk);
        #1 active = 1'b0;
        exp_rd[0] = 8'h96; exp_rd[1] = 8'h96;
        chk("held_rdy_cnt0", rdy_cnt[0], 2);
        chk("held_rdy1_0",   rdy_cyc[0], 4);
        chk("held_rdy2_0",   rdy2_cyc[0], 4 + busy_of(0) + 1);
        chk("held_rdy_cnt1", rdy_cnt[1], 1);
        chk("held_rdy1_1",   rdy_cyc[1], ale_of(1) + 1 + stb_of(1));
        chk("held_rdata0",   rdata[0], exp_rd[0]);
        chk("held_which0",   wrong_stb[0], 0);

        // Reset during the read strobe.
        start_req(1'b1, 1'b0, 1'b1, 16'h2468, 8'h00, 8'h11);
        repeat (4) @(negedge clk);
        chk("pre_rst_rd0", rdn[0], 0);
        chk("pre_rst_rd1", rdn[1], 0);
        reset_n = 1'b0;
        rd_n    = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_rd%0d", d),    rdn[d],   1);
            chk($sformatf("rst_oe%0d", d),    oe[d],    0);
            chk($sformatf("rst_rdata%0d", d), rdata[d], 8'hFF);
            chk($sformatf("rst_ale%0d", d),   ale[d],   0);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (14) @(negedge clk);
        #1 active = 1'b0;
        exp_rd[0] = 8'hFF; exp_rd[1] = 8'hFF;
        chk("rst_no_rdy0", rdy_cnt[0], 0);
        chk("rst_no_rdy1", rdy_cnt[1], 0);

        txn(1'b1, 1'b1, 1'b0, 16'h00FF, 8'h00, 8'h5C);   // alive after reset
        chk("exclusive", excl_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
